// File: rtl/numeric_display_formatter_if.sv
// Request/status bundle between the display formatter and its client.
// Downstream LED controller consumes o_display_D0..D3.
interface numeric_display_formatter_if;
  logic        i_stb;
  logic [15:0] i_value;
  logic        i_hex_mode;
  logic [3:0]  i_dp_mask;
  logic        i_blank_override;
  logic        i_blank;
  logic        o_busy;
  logic        o_done_stb;
  logic        o_overflow;
  logic [7:0]  o_display_D0;
  logic [7:0]  o_display_D1;
  logic [7:0]  o_display_D2;
  logic [7:0]  o_display_D3;

  modport master (
    output i_stb, i_value, i_hex_mode, i_dp_mask, i_blank_override, i_blank,
    input  o_busy, o_done_stb, o_overflow,
           o_display_D0, o_display_D1, o_display_D2, o_display_D3
  );

  modport slave (
    input  i_stb, i_value, i_hex_mode, i_dp_mask, i_blank_override, i_blank,
    output o_busy, o_done_stb, o_overflow,
           o_display_D0, o_display_D1, o_display_D2, o_display_D3
  );
endinterface

// File: rtl/numeric_display_formatter.sv
// 16-bit value to four 7-segment patterns; decimal via serial double-dabble,
// hex via direct nibble encode, with DP, leading-zero blanking and overflow.
module numeric_display_formatter #(
  parameter logic BLANK_DEFAULT = 1'b0
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  numeric_display_formatter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_t;

  state_t      state, state_n;
  logic [15:0] bin_q, bcd_q;
  logic [3:0]  cnt_q;
  logic        hex_q, blank_q, ovf_req_q;
  logic [3:0]  dp_q;
  logic [7:0]  disp_q [4];
  logic        done_q, overflow_q;

  logic [15:0] bcd_adj;
  logic [7:0]  enc [4];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1111110;
      4'h1: seg7 = 7'b0110000;
      4'h2: seg7 = 7'b1101101;
      4'h3: seg7 = 7'b1111001;
      4'h4: seg7 = 7'b0110011;
      4'h5: seg7 = 7'b1011011;
      4'h6: seg7 = 7'b1011111;
      4'h7: seg7 = 7'b1110000;
      4'h8: seg7 = 7'b1111111;
      4'h9: seg7 = 7'b1111011;
      4'hA: seg7 = 7'b1110111;
      4'hB: seg7 = 7'b0011111;
      4'hC: seg7 = 7'b1001110;
      4'hD: seg7 = 7'b0111101;
      4'hE: seg7 = 7'b1001111;
      default: seg7 = 7'b1000111;
    endcase
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.i_stb) begin
          if (!bus.i_hex_mode && (bus.i_value <= 16'd9999)) state_n = CONVERT;
          else                                              state_n = ENCODE;
        end
      end
      CONVERT: if (cnt_q == 4'd15) state_n = ENCODE;
      ENCODE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Blanking walks down from D3; a digit blanks only if every higher one did.
  always_comb begin
    logic [15:0] src;
    logic        blank_run;
    src       = hex_q ? bin_q : bcd_q;
    blank_run = blank_q;
    for (int i = 3; i >= 0; i--) begin
      blank_run = blank_run && (src[4*i +: 4] == 4'h0) && (i != 0);
      if (ovf_req_q)      enc[i] = 8'h02;
      else if (blank_run) enc[i] = {7'b0, dp_q[i]};
      else                enc[i] = {seg7(src[4*i +: 4]), dp_q[i]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      hex_q      <= 1'b0;
      blank_q    <= 1'b0;
      ovf_req_q  <= 1'b0;
      dp_q       <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) disp_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_stb) begin
            bin_q     <= bus.i_value;
            bcd_q     <= '0;
            cnt_q     <= '0;
            hex_q     <= bus.i_hex_mode;
            dp_q      <= bus.i_dp_mask;
            blank_q   <= bus.i_blank_override ? bus.i_blank : BLANK_DEFAULT;
            ovf_req_q <= !bus.i_hex_mode && (bus.i_value > 16'd9999);
          end
        end
        CONVERT: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 4'd1;
        end
        ENCODE: begin
          for (int unsigned i = 0; i < 4; i++) disp_q[i] <= enc[i];
          overflow_q <= ovf_req_q;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy       = (state != IDLE);
  assign bus.o_done_stb   = done_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_display_D0 = disp_q[0];
  assign bus.o_display_D1 = disp_q[1];
  assign bus.o_display_D2 = disp_q[2];
  assign bus.o_display_D3 = disp_q[3];

endmodule

// File: tb/tb_numeric_display_formatter.sv
// Scoreboard bench: each accepted request pushes its expected patterns,
// the done-strobe monitor pops and compares them.
module tb_numeric_display_formatter;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  numeric_display_formatter_if bus ();

  numeric_display_formatter #(.BLANK_DEFAULT(1'b0)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  typedef struct {
    logic [7:0] d [4];
    logic       ovf;
    int         lat;
    int         acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_done  = 0;
  logic mon_en  = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int v);
    logic [6:0] t [16];
    t = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    return t[v];
  endfunction

  function automatic exp_t model(input logic [15:0] v, input logic hex,
                                 input logic [3:0] dp, input logic blank);
    exp_t e;
    int   dig [4];
    bit   lead;
    e.ovf = !hex && (v > 16'd9999);
    e.lat = (hex || e.ovf) ? 1 : 17;
    e.acc_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      if (hex) dig[n] = (v >> (4*n)) & 15;
      else     dig[n] = (int'(v) / (10 ** n)) % 10;
    end
    lead = blank;
    for (int n = 3; n >= 0; n--) begin
      lead = lead && (dig[n] == 0) && (n > 0);
      if (e.ovf)     e.d[n] = 8'h02;
      else if (lead) e.d[n] = {7'h00, dp[n]};
      else           e.d[n] = {seg_ref(dig[n]), dp[n]};
    end
    return e;
  endfunction

  always @(negedge i_clk) begin
    if (mon_en && bus.o_done_stb) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("D0", bus.o_display_D0, e.d[0]);
        check("D1", bus.o_display_D1, e.d[1]);
        check("D2", bus.o_display_D2, e.d[2]);
        check("D3", bus.o_display_D3, e.d[3]);
        check("overflow", bus.o_overflow, e.ovf);
        check("latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((bus.o_busy || exp_q.size() != 0) && k < 60) begin
      @(negedge i_clk);
      k++;
    end
    if (k >= 60) check("timeout", 1, 0);
    @(negedge i_clk);
  endtask

  task automatic send(input logic [15:0] v, input logic hex, input logic [3:0] dp,
                      input logic bo, input logic b);
    exp_t e;
    @(negedge i_clk);
    bus.i_stb = 1'b1; bus.i_value = v; bus.i_hex_mode = hex;
    bus.i_dp_mask = dp; bus.i_blank_override = bo; bus.i_blank = b;
    @(posedge i_clk);
    #1;
    e = model(v, hex, dp, bo ? b : 1'b0);
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    bus.i_stb = 1'b0;
    bus.i_value = ~v; bus.i_hex_mode = ~hex; bus.i_dp_mask = ~dp; bus.i_blank = ~b;
  endtask

  initial begin
    int d0;
    bus.i_stb = 1'b0; bus.i_value = '0; bus.i_hex_mode = 1'b0;
    bus.i_dp_mask = '0; bus.i_blank_override = 1'b0; bus.i_blank = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done_stb, 0);
    check("rst_ovf", bus.o_overflow, 0);
    check("rst_disp", {bus.o_display_D3, bus.o_display_D2, bus.o_display_D1, bus.o_display_D0}, 0);
    mon_en = 1'b1;

    send(16'd1234, 1'b0, 4'b0000, 1'b0, 1'b0); wait_idle();
    check("d1234_D3", bus.o_display_D3, 8'h60);
    check("d1234_D0", bus.o_display_D0, 8'h66);

    send(16'hBEEF, 1'b1, 4'b0000, 1'b0, 1'b0);
    check("hex_busy_on", bus.o_busy, 1);
    @(posedge i_clk); #1;
    check("hex_busy_off", bus.o_busy, 0);
    wait_idle();
    check("beef_D3", bus.o_display_D3, 8'h3E);

    send(16'd10000, 1'b0, 4'b1111, 1'b0, 1'b0); wait_idle();
    send(16'd1234, 1'b0, 4'b0100, 1'b0, 1'b0); wait_idle();
    check("dp_D2", bus.o_display_D2, 8'hDB);

    send(16'd7, 1'b0, 4'b0000, 1'b1, 1'b1); wait_idle();
    send(16'd0, 1'b0, 4'b0000, 1'b1, 1'b1); wait_idle();
    send(16'd0, 1'b0, 4'b1000, 1'b1, 1'b1); wait_idle();
    check("blank_dp_D3", bus.o_display_D3, 8'h01);
    send(16'd9999, 1'b0, 4'b0000, 1'b1, 1'b1); wait_idle();
    send(16'h00A0, 1'b1, 4'b0001, 1'b1, 1'b1); wait_idle();
    send(16'd65535, 1'b0, 4'b0000, 1'b1, 1'b1); wait_idle();

    // strobes while busy must be ignored
    d0 = n_done;
    send(16'd1234, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      bus.i_stb = (c == 3 || c == 8);
      bus.i_value = 16'd4321;
      @(posedge i_clk); #1;
    end
    bus.i_stb = 1'b0;
    wait_idle();
    repeat (20) @(negedge i_clk);
    check("ignored_stb_dones", n_done - d0, 1);
    check("ignored_stb_D0", bus.o_display_D0, 8'h66);

    // reset mid-conversion aborts without a done pulse
    d0 = n_done;
    send(16'd5678, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (9) @(posedge i_clk);
    #1 i_reset_n = 1'b0;
    exp_q.delete();
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    repeat (20) @(negedge i_clk);
    check("abort_busy", bus.o_busy, 0);
    check("abort_disp", {bus.o_display_D3, bus.o_display_D2, bus.o_display_D1, bus.o_display_D0}, 0);
    check("abort_dones", n_done - d0, 0);
    send(16'd5678, 1'b0, 4'b0000, 1'b0, 1'b0); wait_idle();

    for (int r = 0; r < 24; r++) begin
      send(16'($urandom_range(0, 65535)) >> $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
